// File: rtl/fill_drawer.sv
// Framebuffer fill engine: writes FILL_VALUE to pixels 0..PIXELS_COUNT-1, one per clock.
// Optional FILL_DRAWER_STRIPES_EN: write_data = FILL_VALUE ^ write_addr[0].
module fill_drawer #(
  parameter int   PIXELS_COUNT = 5,
  parameter logic FILL_VALUE   = 1'b0,
  parameter int   ADDR_WIDTH   =
    (PIXELS_COUNT > 1) ? $clog2(PIXELS_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_data
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(PIXELS_COUNT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      data_q  <= FILL_VALUE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          addr_d  = '0;
          ready_d = 1'b0;
          we_d    = 1'b1;
        end
      end
      FILL: begin
        // Stop on the last pixel so the counter never enters unused addresses.
        if (addr_q == LAST) begin
          state_d = IDLE;
          addr_d  = '0;
          ready_d = 1'b1;
          we_d    = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        ready_d = 1'b1;
        we_d    = 1'b0;
      end
    endcase
`ifdef FILL_DRAWER_STRIPES_EN
    data_d = FILL_VALUE ^ addr_d[0];
`else
    data_d = FILL_VALUE;
`endif
  end

  assign ready        = ready_q;
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;

endmodule

// File: tb/tb_fill_drawer.sv
// Self-checking bench for fill_drawer: timeline model of fills plus
// literal checks of address order, idle gaps and reset abort.
module tb_fill_drawer;

  localparam int   N  = 5;
  localparam logic FV = 1'b0;
  localparam int   AW = 3;

`ifdef FILL_DRAWER_STRIPES_EN
  localparam bit STRIPES = 1'b1;
`else
  localparam bit STRIPES = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic          write_data;

  int tests = 0;
  int fails = 0;

  fill_drawer #(
    .PIXELS_COUNT(N),
    .FILL_VALUE  (FV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ready       (ready),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data)
  );

  always #5 clk = ~clk;

  // Model: a fill is a window of N cycles beginning at cycle t0.
  int cyc = 0;
  int t0 = 0;
  bit have = 1'b0;

  function automatic bit busy_at(int c);
    return have && (c - t0) >= 0 && (c - t0) < N;
  endfunction

  always @(posedge clk) begin
    if (rst) have = 1'b0;
    else if (!busy_at(cyc) && start) begin
      t0   = cyc + 1;
      have = 1'b1;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    logic          e_we, e_rdy, e_d;
    logic [AW-1:0] e_a;
    int            off;
    if (!rst && busy_at(cyc)) begin
      off   = cyc - t0;
      e_we  = 1'b1;
      e_rdy = 1'b0;
      e_a   = AW'(off);
    end else begin
      e_we  = 1'b0;
      e_rdy = 1'b1;
      e_a   = '0;
    end
    e_d = FV ^ (STRIPES & e_a[0]);
    tests++;
    if (ready !== e_rdy || write_enable !== e_we ||
        write_addr !== e_a || write_data !== e_d) begin
      fails++;
      $display("FAIL cycle%0d got rdy=%b we=%b a=%0d d=%b exp rdy=%b we=%b a=%0d d=%b",
               cyc, ready, write_enable, write_addr, write_data,
               e_rdy, e_we, e_a, e_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(string name, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    check(name, int'(ready), 1);
  endtask

  task automatic wait_addr(string name, int a);
    int n = 0;
    @(negedge clk);
    while (!(write_enable && write_addr == AW'(a)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(write_addr), a);
  endtask

  initial begin
    logic [AW-1:0] aq[$];
    logic          dq[$];
    int            nw;
    int            exp_d;

    tick();
    tick();
    rst = 1'b0;

    // 1: idle with no start
    repeat (20) tick();
    check("idle_ready", int'(ready), 1);
    check("idle_we", int'(write_enable), 0);

    // 2: single pulse, capture writes
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (write_enable) begin
        aq.push_back(write_addr);
        dq.push_back(write_data);
      end
    end
    check("pulse_nwrites", aq.size(), 5);
    for (int i = 0; i < aq.size(); i++) begin
      check("pulse_addr", int'(aq[i]), i);
      exp_d = STRIPES ? (i % 2) : 0;
      check("pulse_data", int'(dq[i]), exp_d);
    end
    check("pulse_ready_after", int'(ready), 1);

    // 3: three sequential fills
    repeat (3) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_ready("seq_ready");
      tick();
    end

    // 4: start held high: 5 writes then 1 ready cycle, repeating
    start = 1'b1;
    @(posedge clk);
    nw = 0;
    repeat (18) begin
      @(negedge clk);
      if (write_enable) nw++;
    end
    check("held_writes", nw, 15);
    check("held_gap_ready", int'(ready), 1);
    tick();
    start = 1'b0;
    wait_ready("held_end");

    // 5: start re-pulsed mid-fill is ignored
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr("mid_addr2", 2);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    nw = 1;
    repeat (8) begin
      @(negedge clk);
      if (write_enable) nw++;
    end
    check("mid_no_extra", nw, 3);

    // 6: reset mid-fill aborts immediately
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr("rst_addr3", 3);
    #1 rst = 1'b1;
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_we", int'(write_enable), 0);
    check("rst_addr", int'(write_addr), 0);
    check("rst_data", int'(write_data), int'(FV));
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("rst_no_resume", int'(write_enable), 0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
